// File: rtl/fft_specavg_pkg.sv
// Shared defaults and state encoding for the
// frame-averaged FFT power spectrum block.
package fft_specavg_pkg;

   localparam int IW_DEF     = 16;
   localparam int LGSIZE_DEF = 10;
   localparam int LGAVG_DEF  = 2;

   // Exact re^2 + im^2 of IW-bit signed parts fits 2*IW unsigned bits.
   function automatic int pw_of(input int iw);
      return 2 * iw;
   endfunction

   typedef enum logic {
      WAIT_SYNC = 1'b0,
      RUN       = 1'b1
   } state_t;

endpackage

// File: rtl/fft_specavg_mem.sv
// Per-bin accumulator RAM: one registered read port,
// one write port, both advancing only on ce.
module fft_specavg_mem
   import fft_specavg_pkg::*;
#(
   parameter int AW = LGSIZE_DEF,
   parameter int DW = 34
) (
   input  logic          clk,
   input  logic          ce,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] ram [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (ce) begin
         if (we)
            ram[waddr] <= wdata;
         rdata <= ram[raddr];
      end
   end

endmodule

// File: rtl/fft_specavg.sv
// Averages |X[k]|^2 over 2^LGAVG consecutive FFT frames,
// emitting one averaged frame per group.
module fft_specavg
   import fft_specavg_pkg::*;
#(
   parameter int IW     = IW_DEF,
   parameter int LGSIZE = LGSIZE_DEF,
   parameter int LGAVG  = LGAVG_DEF,
   parameter int PW     = pw_of(IW)
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_ce,
   input  logic [2*IW-1:0] i_sample,
   input  logic          i_sync,
   output logic          o_valid,
   output logic [PW-1:0] o_power,
   output logic          o_sync
);

   localparam int AW = PW + LGAVG;
   localparam int FW = (LGAVG > 0) ? LGAVG : 1;
   localparam int SW = 2 * IW;
   localparam logic [FW-1:0] LAST_FRAME = FW'((1 << LGAVG) - 1);

   state_t            state;
   logic [LGSIZE-1:0] bin_cnt, bin_cur;
   logic [FW-1:0]     frame_cnt, frame_cur;
   logic              accept;

   logic              v1, v2, v3;
   logic signed [IW-1:0] re1, im1;
   logic signed [SW-1:0] sq_re, sq_im;
   logic [LGSIZE-1:0] bin1, bin2, bin3;
   logic [3:1]        first_p, last_p, sync_p;
   logic [AW-1:0]     rd1, rd2, sum3;

   // A sync mid-frame restarts the group at bin 0, frame 0.
   always_comb begin
      accept    = i_ce && (state == RUN || i_sync);
      bin_cur   = i_sync ? '0 : bin_cnt;
      frame_cur = (i_sync && bin_cnt != '0) ? '0 : frame_cnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         re1     <= $signed(i_sample[2*IW-1:IW]);
         im1     <= $signed(i_sample[IW-1:0]);
         sq_re   <= SW'(re1) * SW'(re1);
         sq_im   <= SW'(im1) * SW'(im1);
         rd2     <= rd1;
         sum3    <= (first_p[2] ? '0 : rd2)
                  + AW'($unsigned(sq_re))
                  + AW'($unsigned(sq_im));
         bin1    <= bin_cur;
         bin2    <= bin1;
         bin3    <= bin2;
         first_p <= {first_p[2:1], frame_cur == '0};
         last_p  <= {last_p[2:1], frame_cur == LAST_FRAME};
         sync_p  <= {sync_p[2:1], bin_cur == '0};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state     <= WAIT_SYNC;
         bin_cnt   <= '0;
         frame_cnt <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         o_valid   <= 1'b0;
         o_sync    <= 1'b0;
         o_power   <= '0;
      end else if (i_ce) begin
         v1      <= accept;
         v2      <= v1;
         v3      <= v2;
         o_valid <= v3 && last_p[3];
         o_sync  <= v3 && last_p[3] && sync_p[3];
         if (v3 && last_p[3])
            o_power <= PW'(sum3 >> LGAVG);
         if (accept) begin
            state   <= RUN;
            bin_cnt <= bin_cur + LGSIZE'(1);
            if (bin_cur == '1)
               frame_cnt <= (frame_cur == LAST_FRAME) ? '0
                          : frame_cur + FW'(1);
            else
               frame_cnt <= frame_cur;
         end
      end
   end

   fft_specavg_mem #(
      .AW (LGSIZE),
      .DW (AW)
   ) u_mem (
      .clk   (i_clk),
      .ce    (i_ce),
      .we    (v3 && i_reset_n),
      .waddr (bin3),
      .wdata (sum3),
      .raddr (bin_cur),
      .rdata (rd1)
   );

endmodule

// File: tb/tb_fft_specavg.sv
// Scoreboard bench for fft_specavg: directed frame groups with
// expected averaged powers queued at issue and checked at output.
module tb_fft_specavg;

   localparam int IW     = 16;
   localparam int LGSIZE = 10;
   localparam int LGAVG  = 2;
   localparam int PW     = 32;
   localparam int NBIN   = 1 << LGSIZE;
   localparam int NAVG   = 1 << LGAVG;

   typedef struct {
      logic [PW-1:0] pw;
      logic          sync;
      int            tag;
   } exp_t;

   logic            clk      = 1'b0;
   logic            rst_n    = 1'b0;
   logic            ce       = 1'b0;
   logic [2*IW-1:0] sample   = '0;
   logic            sync_in  = 1'b0;
   logic            valid;
   logic            sync_out;
   logic [PW-1:0]   power;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ce_edges = 0;
   int   gap      = 0;

   fft_specavg #(
      .IW     (IW),
      .LGSIZE (LGSIZE),
      .LGAVG  (LGAVG),
      .PW     (PW)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_ce      (ce),
      .i_sample  (sample),
      .i_sync    (sync_in),
      .o_valid   (valid),
      .o_power   (power),
      .o_sync    (sync_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ce) ce_edges++;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Each output is consumed on the i_ce edge after it appears.
   always @(negedge clk) begin
      if (ce) begin
         check("sync_gated", 64'(sync_out & ~valid), 64'(0));
         if (valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got power %0h expected none",
                        power);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("power", 64'(power), 64'(e.pw));
               check("out_sync", 64'(sync_out), 64'(e.sync));
               check("latency", 64'(ce_edges), 64'(e.tag));
            end
         end
      end
   end

   task automatic send(input int re, input int im, input logic s,
                       input logic chk, input logic [PW-1:0] pw);
      repeat (gap) begin
         ce = 1'b0;
         @(posedge clk); #1;
      end
      ce      = 1'b1;
      sync_in = s;
      sample  = {IW'(re), IW'(im)};
      if (chk)
         sb.push_back('{pw, s, ce_edges + 4});
      @(posedge clk); #1;
      ce      = 1'b0;
      sync_in = 1'b0;
   endtask

   task automatic run_group(input int mode);
      for (int f = 0; f < NAVG; f++) begin
         for (int k = 0; k < NBIN; k++) begin
            int re, im;
            logic [PW-1:0] pw;
            case (mode)
               0: begin re = 3; im = 4; pw = 25; end
               1: begin re = -32768; im = -32768; pw = 32'h8000_0000; end
               2: begin re = k * (f + 1); im = 0; pw = PW'((k * k * 30) >> 2); end
               3: begin re = 1; im = 2; pw = 5; end
               default: begin re = 7; im = -1; pw = 50; end
            endcase
            send(re, im, k == 0, f == NAVG - 1, pw);
         end
      end
   endtask

   task automatic filler();
      repeat (8) send(0, 0, 1'b0, 1'b0, '0);
   endtask

   task automatic reset_checks();
      check("reset_valid", 64'(valid), 64'(0));
      check("reset_sync", 64'(sync_out), 64'(0));
      check("reset_power", 64'(power), 64'(0));
   endtask

   initial begin
      rst_n   = 1'b0;
      ce      = 1'b1;
      sync_in = 1'b1;
      sample  = 32'h1234_5678;
      repeat (3) begin
         @(posedge clk); #1;
         reset_checks();
      end
      rst_n   = 1'b1;
      ce      = 1'b0;
      sync_in = 1'b0;

      gap = 0;
      run_group(0);
      filler();
      run_group(1);
      filler();
      run_group(2);
      filler();

      gap = 2;
      run_group(0);
      filler();
      gap = 0;

      // Frame 1 is cut short by a sync at bin 500.
      for (int f = 0; f < 2; f++)
         for (int k = 0; k < NBIN; k++)
            if (f == 0 || k < 500)
               send(100, 100, k == 0, 1'b0, '0);
      run_group(3);
      filler();

      for (int f = 0; f < 3; f++)
         for (int k = 0; k < NBIN; k++)
            if (f < 2 || k < 300)
               send(9, 9, k == 0, 1'b0, '0);
      rst_n  = 1'b0;
      ce     = 1'b1;
      sample = 32'h0005_0005;
      @(posedge clk); #1;
      reset_checks();
      rst_n = 1'b1;
      ce    = 1'b0;
      repeat (20) send(11, 11, 1'b0, 1'b0, '0);
      run_group(4);
      filler();

      repeat (10) @(posedge clk);
      #1;
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_specavg.md
FFT_SPECAVG -- requirements
Module: fft_specavg

Interface
REQ-001 SHALL have parameter IW, default 16: signed width of each real/imag input component.
REQ-002 SHALL have parameter LGSIZE, default 10: log2 of FFT frame length; legal range 3..12.
REQ-003 SHALL have parameter LGAVG, default 2: log2 of the number of frames averaged per output frame; legal range 0..4.
REQ-004 SHALL have parameter PW, default 2*IW: width of output power word.
REQ-005 i_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 i_reset_n  input  1  reset, synchronous, active-low.
REQ-007 i_ce  input  1  clock enable; one input sample accepted per asserted cycle.
REQ-008 i_sample  input  2*IW  FFT bin, real in upper IW bits, imaginary in lower IW bits, two's complement.
REQ-009 i_sync  input  1  marks bin 0 of an FFT frame; qualified by i_ce.
REQ-010 o_valid  output  1  o_power holds a valid averaged bin; consumer qualifies with i_ce.
REQ-011 o_power  output  PW  averaged power, unsigned.
REQ-012 o_sync  output  1  marks bin 0 of an averaged output frame; only high with o_valid.

Function
REQ-013 SHALL compute per-bin power p = re*re + im*im exactly, unsigned, PW bits; max 2^(2*IW-1) at re=im=-2^(IW-1), no saturation needed.
REQ-014 SHALL keep an accumulator memory of 2^LGSIZE words, PW+LGAVG bits each, indexed by bin counter.
REQ-015 SHALL hold state WAIT_SYNC after reset, discarding samples until the first i_ce&&i_sync, then enter RUN.
REQ-016 In RUN, the bin counter SHALL increment per i_ce sample and wrap 2^LGSIZE-1 -> 0; the frame counter (LGAVG bits) SHALL increment at each wrap and wrap 2^LGAVG-1 -> 0.
REQ-017 Frame 0 of a group SHALL write acc = p; frames 1..2^LGAVG-1 SHALL write acc = mem[bin] + p.
REQ-018 On the last frame of a group, SHALL output o_power = (mem[bin] + p) >> LGAVG (truncating), o_valid=1, o_sync=1 for bin 0 only; otherwise o_valid=0, o_sync=0.
REQ-019 LGAVG=0 SHALL output p for every bin of every frame.
REQ-020 Pipeline SHALL advance only on i_ce; outputs hold between i_ce cycles.
REQ-021 Latency SHALL be exactly 4 i_ce cycles from sample accept to matching o_power/o_valid/o_sync.
REQ-022 No read/write bypass required: same bin recurs after 2^LGSIZE >= 8 > 4 samples.
REQ-023 i_sync when bin counter != 0 (resync) SHALL force bin=0, frame=0, treat that sample as bin 0 frame 0; partial group produces no output; in-flight pipeline outputs still complete.
REQ-024 i_sync when bin counter == 0 SHALL be accepted with no effect on counters.

Reset
REQ-025 While i_reset_n=0 at a clock edge: o_valid=0, o_sync=0, o_power=0, state=WAIT_SYNC, counters=0, pipeline valid flags=0.
REQ-026 Reset SHALL take effect regardless of i_ce and mid-frame; accumulator RAM contents need not be cleared (frame 0 overwrites).

Structure
REQ-027 Shared package SHALL hold IW/LGSIZE/LGAVG defaults, PW derivation, and state encoding (WAIT_SYNC, RUN).
REQ-028 Accumulator SHALL be a separate sub-module fft_specavg_mem: simple dual-port RAM, one registered read, one write port, both gated by i_ce.
REQ-029 Squaring SHALL map to hardware multipliers with registered inputs and outputs.

Verification
REQ-030 LGAVG=2, LGSIZE=10, constant re=3, im=4 with sync per frame -> no o_valid during frames 0-2; frame 3 gives 1024 o_valid with o_power=25, o_sync only on first, 4 i_ce after frame-3 bin 0.
REQ-031 re=im=-32768 all bins, LGAVG=2 -> o_power=0x80000000 every bin; no wrap.
REQ-032 Bin k carries re=k, im=0 in frames 0..3 scaled by frame f (re=k*(f+1)) -> o_power = (k^2*30)>>2 per bin.
REQ-033 i_ce asserted every 3rd clock, same stimulus as REQ-030 -> identical output sequence counted in i_ce cycles.
REQ-034 i_sync injected at bin 500 of frame 1 -> no output for that group; output resumes 4 frames later with correct values.
REQ-035 i_reset_n low for one clock mid-frame 2 -> outputs 0 next edge; samples ignored until next i_sync; next full group averages correctly.
